// File: rtl/fp_pkg.sv
// Shared binary32 types and constants for the floating-point pipelines.
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } fp_32b_t;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rounding_mode_t;

    localparam logic [31:0] FP_QNAN       = 32'h7FC0_0000;
    localparam logic [31:0] FP_POS_INF    = 32'h7F80_0000;
    localparam logic [30:0] FP_MAX_FINITE = 31'h7F7F_FFFF;
    localparam int          FP_BIAS       = 127;

endpackage

// File: rtl/fp_round_decide.sv
// Round-increment decision from mode, sign, lsb, guard and sticky.
// Reserved mode encodings fall back to round-to-nearest-even.
module fp_round_decide
    import fp_pkg::*;
(
    input  logic [2:0] mode,
    input  logic       sign,
    input  logic       lsb,
    input  logic       g,
    input  logic       st,
    output logic       inc
);

    always_comb begin
        inc = 1'b0;
        case (mode)
            RM_RNE:  inc = g & (st | lsb);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (g | st);
            RM_RUP:  inc = ~sign & (g | st);
            RM_RMM:  inc = g;
            default: inc = g & (st | lsb);
        endcase
    end

endmodule

// File: rtl/fp_mul_round_pipeline.sv
// Multiply back-end: normalize, round, pack and flag in two registered stages.
// Define FP_MUL_STICKY_FLAGS_EN to add clear_flags/fflags accumulated exception flags.
module fp_mul_round_pipeline
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_data_in,
    input  logic [47:0] product,
    input  logic [8:0]  exp_sum,
    input  logic        sign_bit,
    input  logic [2:0]  rounding_mode,
    input  logic        special_case,
    input  logic [31:0] special_result,
    input  logic        input_is_invalid,
    input  logic        input_is_flushed,
`ifdef FP_MUL_STICKY_FLAGS_EN
    input  logic        clear_flags,
    output logic [4:0]  fflags,
`endif
    output logic [31:0] out,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact,
    output logic        invalid_operation,
    output logic        valid_data_out
);

    localparam logic signed [9:0] BIAS     = 10'(FP_BIAS);
    localparam logic signed [9:0] EXP_MAX  = 10'sd255;
    localparam logic signed [9:0] EXP_ZERO = 10'sd0;

    // Stage N: normalize the product
    logic [22:0]        n_mant;
    logic               n_g;
    logic               n_st;
    logic signed [9:0]  n_exp;

    always_comb begin
        if (product[47]) begin
            n_mant = product[46:24];
            n_g    = product[23];
            n_st   = |product[22:0];
            n_exp  = $signed({1'b0, exp_sum}) - BIAS + 10'sd1;
        end else begin
            n_mant = product[45:23];
            n_g    = product[22];
            n_st   = |product[21:0];
            n_exp  = $signed({1'b0, exp_sum}) - BIAS;
        end
    end

    logic               s1_valid;
    logic [22:0]        s1_mant;
    logic               s1_g;
    logic               s1_st;
    logic signed [9:0]  s1_exp;
    logic               s1_sign;
    logic [2:0]         s1_mode;
    logic               s1_special;
    logic [31:0]        s1_special_result;
    logic               s1_invalid;
    logic               s1_flushed;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid          <= 1'b0;
            s1_mant           <= '0;
            s1_g              <= 1'b0;
            s1_st             <= 1'b0;
            s1_exp            <= '0;
            s1_sign           <= 1'b0;
            s1_mode           <= '0;
            s1_special        <= 1'b0;
            s1_special_result <= '0;
            s1_invalid        <= 1'b0;
            s1_flushed        <= 1'b0;
        end else begin
            s1_valid          <= valid_data_in;
            s1_mant           <= n_mant;
            s1_g              <= n_g;
            s1_st             <= n_st;
            s1_exp            <= n_exp;
            s1_sign           <= sign_bit;
            s1_mode           <= rounding_mode;
            s1_special        <= special_case;
            s1_special_result <= special_result;
            s1_invalid        <= input_is_invalid;
            s1_flushed        <= input_is_flushed;
        end
    end

    // Stage R: round, range-check and select the final result
    logic               r_inc;
    logic [23:0]        r_sum;
    logic signed [9:0]  r_exp;
    logic               r_to_inf;
    fp_32b_t            r_out;
    logic               r_ovf;
    logic               r_unf;
    logic               r_nx;
    logic               r_nv;

    fp_round_decide u_round_decide (
        .mode (s1_mode),
        .sign (s1_sign),
        .lsb  (s1_mant[0]),
        .g    (s1_g),
        .st   (s1_st),
        .inc  (r_inc)
    );

    assign r_sum = {1'b0, s1_mant} + {23'd0, r_inc};
    assign r_exp = s1_exp + $signed({9'd0, r_sum[23]});

    always_comb begin
        r_to_inf = 1'b0;
        case (s1_mode)
            RM_RTZ:  r_to_inf = 1'b0;
            RM_RDN:  r_to_inf = s1_sign;
            RM_RUP:  r_to_inf = ~s1_sign;
            default: r_to_inf = 1'b1;
        endcase
    end

    always_comb begin
        r_out = '0;
        r_ovf = 1'b0;
        r_unf = 1'b0;
        r_nx  = 1'b0;
        r_nv  = 1'b0;
        if (s1_invalid) begin
            r_out = FP_QNAN;
            r_nv  = 1'b1;
        end else if (s1_special) begin
            r_out = s1_special_result;
            r_nx  = s1_flushed;
        end else if (r_exp >= EXP_MAX) begin
            r_out = r_to_inf ? {s1_sign, FP_POS_INF[30:0]} : {s1_sign, FP_MAX_FINITE};
            r_ovf = 1'b1;
            r_nx  = 1'b1;
        end else if (r_exp <= EXP_ZERO) begin
            r_out = {s1_sign, 31'd0};
            r_unf = 1'b1;
            r_nx  = 1'b1;
        end else begin
            // on carry-out r_sum[22:0] is already zero, which is the required mantissa
            r_out = {s1_sign, r_exp[7:0], r_sum[22:0]};
            r_nx  = s1_g | s1_st;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out               <= '0;
            overflow          <= 1'b0;
            underflow         <= 1'b0;
            inexact           <= 1'b0;
            invalid_operation <= 1'b0;
            valid_data_out    <= 1'b0;
        end else begin
            out               <= r_out;
            overflow          <= r_ovf;
            underflow         <= r_unf;
            inexact           <= r_nx;
            invalid_operation <= r_nv;
            valid_data_out    <= s1_valid;
        end
    end

`ifdef FP_MUL_STICKY_FLAGS_EN
    // Flags of a beat presented together with clear_flags are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            fflags <= '0;
        end else begin
            fflags <= (clear_flags ? 5'd0 : fflags)
                    | ({5{valid_data_out}} & {invalid_operation, 1'b0, overflow, underflow, inexact});
        end
    end
`endif

endmodule

// File: tb/tb_fp_mul_round_pipeline.sv
// Self-checking bench for fp_mul_round_pipeline: directed vectors, random
// back-to-back traffic against an arithmetic reference model, reset flush.
module tb_fp_mul_round_pipeline;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_data_in;
    logic [47:0] product;
    logic [8:0]  exp_sum;
    logic        sign_bit;
    logic [2:0]  rounding_mode;
    logic        special_case;
    logic [31:0] special_result;
    logic        input_is_invalid;
    logic        input_is_flushed;
    logic [31:0] out;
    logic        overflow, underflow, inexact, invalid_operation, valid_data_out;
`ifdef FP_MUL_STICKY_FLAGS_EN
    logic        clear_flags;
    logic [4:0]  fflags;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_mul_round_pipeline dut (
        .clk               (clk),
        .rst               (rst),
        .valid_data_in     (valid_data_in),
        .product           (product),
        .exp_sum           (exp_sum),
        .sign_bit          (sign_bit),
        .rounding_mode     (rounding_mode),
        .special_case      (special_case),
        .special_result    (special_result),
        .input_is_invalid  (input_is_invalid),
        .input_is_flushed  (input_is_flushed),
`ifdef FP_MUL_STICKY_FLAGS_EN
        .clear_flags       (clear_flags),
        .fflags            (fflags),
`endif
        .out               (out),
        .overflow          (overflow),
        .underflow         (underflow),
        .inexact           (inexact),
        .invalid_operation (invalid_operation),
        .valid_data_out    (valid_data_out)
    );

    typedef struct {
        logic [47:0] p;
        int          es;
        bit          s;
        int          mode;
        bit          sc;
        logic [31:0] sr;
        bit          inv;
        bit          fl;
        logic [31:0] exp_out;
        logic [3:0]  exp_flags;   // {overflow, underflow, inexact, invalid}
    } vec_t;

    // Reference: exact remainder-vs-half comparison on the integer product.
    function automatic logic [35:0] ref_model(input logic [47:0] p, input int es, input bit s,
                                              input int mode, input bit sc, input logic [31:0] sr,
                                              input bit inv, input bit fl);
        longint unsigned full, sig, rem, half;
        int  sh, e;
        bit  up, to_inf;
        if (inv) return {32'h7FC0_0000, 4'b0001};
        if (sc)  return {sr, 1'b0, 1'b0, fl, 1'b0};
        full = 64'(p);
        sh   = p[47] ? 24 : 23;
        sig  = full >> sh;
        rem  = full & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        e    = es - 127 + (p[47] ? 1 : 0);
        case (mode)
            1:       up = 0;
            2:       up = s && rem != 0;
            3:       up = !s && rem != 0;
            4:       up = rem >= half;
            default: up = rem > half || (rem == half && sig[0]);
        endcase
        sig = sig + (up ? 64'd1 : 64'd0);
        if (sig >= (64'd1 << 24)) begin
            sig = sig >> 1;
            e   = e + 1;
        end
        if (e >= 255) begin
            to_inf = (mode == 0) || (mode == 4) || (mode == 2 && s) || (mode == 3 && !s);
            return {s, to_inf ? 31'h7F80_0000 : 31'h7F7F_FFFF, 4'b1010};
        end
        if (e <= 0) return {s, 31'd0, 4'b0110};
        return {s, e[7:0], sig[22:0], 1'b0, 1'b0, (rem != 0), 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [47:0] p, input int es, input bit s, input int mode,
                         input bit sc, input logic [31:0] sr, input bit inv, input bit fl);
        valid_data_in    = v;
        product          = p;
        exp_sum          = 9'(es);
        sign_bit         = s;
        rounding_mode    = 3'(mode);
        special_case     = sc;
        special_result   = sr;
        input_is_invalid = inv;
        input_is_flushed = fl;
    endtask

    task automatic drive_idle();
        drive(0, 48'd0, 0, 0, 0, 0, 32'd0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        tick();
        tick();
        total++;
        if (valid_data_out !== 1'b0 || out !== 32'd0 ||
            {overflow, underflow, inexact, invalid_operation} !== 4'b0000) begin
            bad++;
            $display("FAIL reset: valid=%b out=%h flags=%b, want valid=0 out=0 flags=0000",
                     valid_data_out, out, {overflow, underflow, inexact, invalid_operation});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        vec_t vecs[13];
        vecs[0]  = '{48'h9000_0000_0000, 254, 0, 0, 0, 32'h0, 0, 0, 32'h4010_0000, 4'b0000};
        vecs[1]  = '{48'h7FFF_FFC0_0000, 254, 0, 0, 0, 32'h0, 0, 0, 32'h4000_0000, 4'b0010};
        vecs[2]  = '{48'h7FFF_FFC0_0000, 254, 0, 1, 0, 32'h0, 0, 0, 32'h3FFF_FFFF, 4'b0010};
        vecs[3]  = '{48'h4000_0000_0000, 508, 0, 0, 0, 32'h0, 0, 0, 32'h7F80_0000, 4'b1010};
        vecs[4]  = '{48'h4000_0000_0000, 508, 0, 1, 0, 32'h0, 0, 0, 32'h7F7F_FFFF, 4'b1010};
        vecs[5]  = '{48'h4000_0000_0000, 508, 0, 2, 0, 32'h0, 0, 0, 32'h7F7F_FFFF, 4'b1010};
        vecs[6]  = '{48'h4000_0000_0000, 508, 1, 3, 0, 32'h0, 0, 0, 32'hFF7F_FFFF, 4'b1010};
        vecs[7]  = '{48'h4000_0000_0000, 100, 1, 0, 0, 32'h0, 0, 0, 32'h8000_0000, 4'b0110};
        vecs[8]  = '{48'h4000_0000_0000, 254, 0, 0, 0, 32'h0, 1, 0, 32'h7FC0_0000, 4'b0001};
        vecs[9]  = '{48'h4000_0000_0000, 254, 0, 0, 1, 32'hFF80_0000, 0, 0, 32'hFF80_0000, 4'b0000};
        vecs[10] = '{48'h4000_0000_0000, 254, 0, 0, 1, 32'h0000_0000, 0, 1, 32'h0000_0000, 4'b0010};
        vecs[11] = '{48'h4000_0000_0000, 381, 0, 0, 0, 32'h0, 0, 0, 32'h7F00_0000, 4'b0000};
        vecs[12] = '{48'h4000_0000_0000, 128, 0, 0, 0, 32'h0, 0, 0, 32'h0080_0000, 4'b0000};
        foreach (vecs[i]) begin
            drive(1, vecs[i].p, vecs[i].es, vecs[i].s, vecs[i].mode, vecs[i].sc, vecs[i].sr,
                  vecs[i].inv, vecs[i].fl);
            tick();
            drive_idle();
            total++;
            if (valid_data_out !== 1'b0) begin
                bad++;
                $display("FAIL dir%0d_early_valid: valid=%b want 0", i, valid_data_out);
            end
            tick();
            total++;
            if (valid_data_out !== 1'b1 || out !== vecs[i].exp_out ||
                {overflow, underflow, inexact, invalid_operation} !== vecs[i].exp_flags) begin
                bad++;
                $display("FAIL dir%0d: valid=%b out=%h flags=%b, want valid=1 out=%h flags=%b",
                         i, valid_data_out, out, {overflow, underflow, inexact, invalid_operation},
                         vecs[i].exp_out, vecs[i].exp_flags);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] exp_q[$];
        int          cyc_q[$];
        logic [35:0] e;
        logic [47:0] p;
        int          es, mode, sel, cyc;
        bit          s, sc, inv, fl, v, want_v;
        logic [31:0] sr;
        cyc = 0;
        for (int i = 0; i < 402; i++) begin
            want_v = (cyc_q.size() > 0) && (cyc_q[0] == cyc);
            total++;
            if (valid_data_out !== want_v) begin
                bad++;
                $display("FAIL b2b_valid cyc%0d: valid=%b want %b", cyc, valid_data_out, want_v);
            end
            if (want_v) begin
                e = exp_q.pop_front();
                void'(cyc_q.pop_front());
                total++;
                if ({out, overflow, underflow, inexact, invalid_operation} !== e) begin
                    bad++;
                    $display("FAIL b2b_data cyc%0d: out=%h flags=%b, want out=%h flags=%b", cyc, out,
                             {overflow, underflow, inexact, invalid_operation}, e[35:4], e[3:0]);
                end
            end
            if (i < 400) begin
                p = {16'($urandom), $urandom};
                if (p[47:46] == 2'b00) p[46] = 1'b1;
                if ($urandom_range(0, 3) == 0) p[22:0] = 23'h40_0000;
                sel = $urandom_range(0, 2);
                es  = (sel == 0) ? $urandom_range(110, 140) :
                      (sel == 1) ? $urandom_range(370, 400) : $urandom_range(2, 508);
                s    = 1'($urandom);
                mode = $urandom_range(0, 4);
                sc   = ($urandom_range(0, 9) == 0);
                inv  = ($urandom_range(0, 9) == 0);
                fl   = 1'($urandom);
                sr   = $urandom;
                v    = ($urandom_range(0, 4) != 0);
                drive(v, p, es, s, mode, sc, sr, inv, fl);
                if (v) begin
                    exp_q.push_back(ref_model(p, es, s, mode, sc, sr, inv, fl));
                    cyc_q.push_back(cyc + 2);
                end
            end else begin
                drive_idle();
            end
            tick();
            cyc++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_drain: %0d beats never came out, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_flush();
        drive(1, 48'h9000_0000_0000, 254, 0, 0, 0, 32'h0, 0, 0);
        tick();
        drive(1, 48'h4000_0000_0000, 508, 0, 0, 0, 32'h0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_idle();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (valid_data_out !== 1'b0 || out !== 32'd0) begin
                bad++;
                $display("FAIL flush%0d: valid=%b out=%h, want valid=0 out=0", k, valid_data_out, out);
            end
            tick();
        end
    endtask

`ifdef FP_MUL_STICKY_FLAGS_EN
    task automatic test_sticky();
        clear_flags = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (fflags !== 5'b00000) begin
            bad++;
            $display("FAIL sticky_reset: fflags=%b want 00000", fflags);
        end
        drive(1, 48'h7FFF_FFC0_0000, 254, 0, 0, 0, 32'h0, 0, 0);
        tick();
        drive(1, 48'h4000_0000_0000, 100, 1, 0, 0, 32'h0, 0, 0);
        tick();
        drive_idle();
        tick();
        tick();
        tick();
        total++;
        if (fflags !== 5'b00011) begin
            bad++;
            $display("FAIL sticky_accum: fflags=%b want 00011", fflags);
        end
        drive(1, 48'h4000_0000_0000, 508, 0, 0, 0, 32'h0, 0, 0);
        tick();
        drive_idle();
        tick();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        total++;
        if (fflags !== 5'b00101) begin
            bad++;
            $display("FAIL sticky_clear_same_beat: fflags=%b want 00101", fflags);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        drive_idle();
`ifdef FP_MUL_STICKY_FLAGS_EN
        clear_flags = 1'b0;
`endif
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_flush();
`ifdef FP_MUL_STICKY_FLAGS_EN
        test_sticky();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
